// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: pipeline-side request bus of the data-memory controller.
//   rd_en       load request (MEM_R_EN)
//   wr_en       store request (MEM_W_EN); wins over rd_en when both are set
//   address     byte address, word-aligned
//   write_data  store data
//   read_data   registered load result
//   ready       high when no access is pending; drives ~freeze of the pipeline
interface sram_mem_ctrl_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output rd_en, wr_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  rd_en, wr_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage controller that turns one 32-bit load/store into two
// 16-bit accesses (low half, then high half) on an asynchronous SRAM.
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        pipeline request bus (slave side)
//   SRAM_DQ    16-bit SRAM data bus, driven only during store phases
//   SRAM_ADDR  SRAM halfword address, {word[16:0], half}
//   SRAM_WE_N  SRAM write enable, active low
//   SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  permanently enabled (0)
module sram_mem_ctrl #(
   parameter int unsigned BASE_ADDR    = 1024,
   parameter int unsigned PHASE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_mem_ctrl_if.slave       bus,
   inout  wire  [15:0]          SRAM_DQ,
   output logic [17:0]          SRAM_ADDR,
   output logic                 SRAM_WE_N,
   output logic                 SRAM_CE_N,
   output logic                 SRAM_OE_N,
   output logic                 SRAM_UB_N,
   output logic                 SRAM_LB_N
);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

   localparam logic [3:0] LastCnt = 4'(PHASE_CYCLES - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        is_wr_q;
   logic [16:0] word_q;
   logic [15:0] wdata_hi_q;
   logic [31:0] rdata_q;
   logic [17:0] sram_addr_q;
   logic        we_n_q;
   logic        dq_oe_q;
   logic [15:0] dq_out_q;

   logic        req;
   logic [31:0] offset;
   logic        last_cnt;
   logic [3:0]  cnt_inc;
   logic        unused_offset;

   assign req      = bus.rd_en | bus.wr_en;
   assign offset   = bus.address - BASE_ADDR;
   assign last_cnt = (cnt_q == LastCnt);
   assign cnt_inc  = cnt_q + 4'd1;

   // Word index keeps only offset[18:2]; higher bits wrap, low bits are the byte offset.
   assign unused_offset = ^{offset[31:19], offset[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         word_q      <= '0;
         wdata_hi_q  <= '0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         we_n_q      <= 1'b1;
         dq_oe_q     <= 1'b0;
         dq_out_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req) begin
                  state_q     <= StLow;
                  cnt_q       <= '0;
                  is_wr_q     <= bus.wr_en;
                  word_q      <= offset[18:2];
                  wdata_hi_q  <= bus.write_data[31:16];
                  sram_addr_q <= {offset[18:2], 1'b0};
                  // First cycle of a phase is never the hold cycle unless the
                  // phase is one cycle long, in which case WE_N stays low.
                  we_n_q      <= ~bus.wr_en;
                  dq_oe_q     <= bus.wr_en;
                  dq_out_q    <= bus.write_data[15:0];
               end
            end
            StLow: begin
               if (last_cnt) begin
                  state_q     <= StHigh;
                  cnt_q       <= '0;
                  sram_addr_q <= {word_q, 1'b1};
                  we_n_q      <= ~is_wr_q;
                  dq_out_q    <= wdata_hi_q;
                  if (!is_wr_q) begin
                     rdata_q[15:0] <= SRAM_DQ;
                  end
               end else begin
                  cnt_q  <= cnt_inc;
                  // Raise WE_N on the final cycle so data/address are held past its rising edge.
                  we_n_q <= ~is_wr_q | (cnt_inc == LastCnt);
               end
            end
            StHigh: begin
               if (last_cnt) begin
                  state_q     <= StDone;
                  cnt_q       <= '0;
                  sram_addr_q <= '0;
                  we_n_q      <= 1'b1;
                  dq_oe_q     <= 1'b0;
                  if (!is_wr_q) begin
                     rdata_q[31:16] <= SRAM_DQ;
                  end
               end else begin
                  cnt_q  <= cnt_inc;
                  we_n_q <= ~is_wr_q | (cnt_inc == LastCnt);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.ready     = ((state_q == StIdle) && !req) || (state_q == StDone);
   assign bus.read_data = rdata_q;

   assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
   assign SRAM_ADDR = sram_addr_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: bench for sram_mem_ctrl. Two instances (PHASE_CYCLES 2 and 1),
// each with its own asynchronous SRAM model; expectations come from a halfword
// memory model and per-cycle timing derived from the phase arithmetic.
module tb_sram_mem_ctrl;
   localparam int unsigned Base   = 1024;
   localparam int          HwSize = 262144;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_mem_ctrl_if ifa ();
   sram_mem_ctrl_if ifb ();

   wire  [15:0] dq_a, dq_b;
   logic [17:0] addr_a, addr_b;
   logic        we_a, we_b;
   logic        ce_a, oe_a, ub_a, lb_a, ce_b, oe_b, ub_b, lb_b;

   sram_mem_ctrl #(.BASE_ADDR(Base), .PHASE_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a),
      .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_UB_N(ub_a),
      .SRAM_LB_N(lb_a)
   );

   sram_mem_ctrl #(.BASE_ADDR(Base), .PHASE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b),
      .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_UB_N(ub_b),
      .SRAM_LB_N(lb_b)
   );

   // SRAM models: write whenever WE_N is low, drive only while the bench expects a load.
   logic [15:0] sram_a [HwSize];
   logic [15:0] sram_b [HwSize];
   logic        sram_oe_a, sram_oe_b;

   assign dq_a = (sram_oe_a && we_a) ? sram_a[addr_a] : 16'hzzzz;
   assign dq_b = (sram_oe_b && we_b) ? sram_b[addr_b] : 16'hzzzz;

   always @(negedge clk) if (rst && !we_a) sram_a[addr_a] <= dq_a;
   always @(negedge clk) if (rst && !we_b) sram_b[addr_b] <= dq_b;

   // Observation of the instance currently under test.
   logic        cur;
   wire         o_ready = cur ? ifb.ready : ifa.ready;
   wire  [31:0] o_rd    = cur ? ifb.read_data : ifa.read_data;
   wire  [17:0] o_addr  = cur ? addr_b : addr_a;
   wire         o_we    = cur ? we_b : we_a;
   wire  [15:0] o_dq    = cur ? dq_b : dq_a;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: halfword memory keyed by instance and halfword index.
   logic [15:0] ref_hw [int];
   logic [31:0] exp_rd [2];

   function automatic logic [15:0] model_hw(input int d, input int hw);
      int key = d * HwSize + hw;
      if (ref_hw.exists(key)) return ref_hw[key];
      return 16'(hw) ^ 16'h5a5a;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] off = a - Base;
      return int'((off >> 2) % 131072);
   endfunction

   task automatic set_inputs(input int d, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] wd);
      ifa.rd_en = 1'b0; ifa.wr_en = 1'b0;
      ifb.rd_en = 1'b0; ifb.wr_en = 1'b0;
      if (d == 0) begin
         ifa.rd_en = rd; ifa.wr_en = wr; ifa.address = a; ifa.write_data = wd;
      end else begin
         ifb.rd_en = rd; ifb.wr_en = wr; ifb.address = a; ifb.write_data = wd;
      end
   endtask

   task automatic idle(input int n);
      set_inputs(0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle ready a", {31'h0, ifa.ready}, 32'h1);
         check("idle ready b", {31'h0, ifb.ready}, 32'h1);
         check("idle we_n a", {31'h0, we_a}, 32'h1);
         check("idle addr a", {14'h0, addr_a}, 32'h0);
         check("idle rd a", ifa.read_data, exp_rd[0]);
         check("idle rd b", ifb.read_data, exp_rd[1]);
         check("tie-offs", {28'h0, ce_a, oe_a, ub_a, lb_a, ce_b, oe_b, ub_b, lb_b}, 32'h0);
      end
   endtask

   // One complete access; returns at the falling edge inside DONE.
   task automatic do_access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input bit scramble,
                            output logic [17:0] first_addr, output logic [31:0] rd_done);
      int p = (d != 0) ? 1 : 2;
      int w = word_of(a);
      bit is_wr = wr;
      if (is_wr) begin
         ref_hw[d * HwSize + 2 * w]     = wd[15:0];
         ref_hw[d * HwSize + 2 * w + 1] = wd[31:16];
      end else begin
         exp_rd[d] = {model_hw(d, 2 * w + 1), model_hw(d, 2 * w)};
      end
      first_addr = '0;
      cur = d[0];
      @(posedge clk); #1;
      set_inputs(d, rd, wr, a, wd);
      @(negedge clk);
      check("accept ready", {31'h0, o_ready}, 32'h0);
      check("accept we_n", {31'h0, o_we}, 32'h1);
      check("accept addr", {14'h0, o_addr}, 32'h0);
      @(posedge clk); #1;
      if (!is_wr) begin
         if (d == 0) sram_oe_a = 1'b1; else sram_oe_b = 1'b1;
      end
      if (scramble) set_inputs(d, 1'b0, 1'b0, $urandom, $urandom);
      for (int k = 0; k < 2 * p; k++) begin
         int ph;
         int pos;
         bit exp_we;
         ph  = k / p;
         pos = k % p;
         exp_we = is_wr ? (p > 1 && pos == p - 1) : 1'b1;
         @(negedge clk);
         if (k == 0) first_addr = o_addr;
         check("busy ready", {31'h0, o_ready}, 32'h0);
         check("busy addr", {14'h0, o_addr}, 32'(2 * w + ph));
         check("busy we_n", {31'h0, o_we}, {31'h0, exp_we});
         if (is_wr) check("busy dq", {16'h0, o_dq}, {16'h0, (ph != 0) ? wd[31:16] : wd[15:0]});
      end
      @(negedge clk);
      check("done ready", {31'h0, o_ready}, 32'h1);
      check("done addr", {14'h0, o_addr}, 32'h0);
      check("done we_n", {31'h0, o_we}, 32'h1);
      check("done read_data", o_rd, exp_rd[d]);
      rd_done = o_rd;
      sram_oe_a = 1'b0;
      sram_oe_b = 1'b0;
   endtask

   typedef struct {
      int          d;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          scr;
      logic [17:0] exp_addr;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [17:0] fa;
      logic [31:0] rdv;
      int          d, op, wi;
      logic [31:0] a, wd;
      bit          scr;

      vecs[0] = '{0, 1'b0, 1'b1, 32'd1028,   32'hDEADBEEF, 1'b0, 18'd2, 32'h00000000};
      vecs[1] = '{0, 1'b1, 1'b0, 32'd1028,   32'h0,        1'b0, 18'd2, 32'hDEADBEEF};
      vecs[2] = '{0, 1'b1, 1'b0, 32'd1024,   32'h0,        1'b0, 18'd0, 32'h5A5B5A5A};
      vecs[3] = '{0, 1'b1, 1'b1, 32'd1032,   32'h12345678, 1'b0, 18'd4, 32'h5A5B5A5A};
      vecs[4] = '{0, 1'b1, 1'b0, 32'd1032,   32'h0,        1'b0, 18'd4, 32'h12345678};
      vecs[5] = '{0, 1'b1, 1'b0, 32'd1028,   32'h0,        1'b1, 18'd2, 32'hDEADBEEF};
      vecs[6] = '{0, 1'b0, 1'b1, 32'd525312, 32'hCAFEF00D, 1'b0, 18'd0, 32'hDEADBEEF};
      vecs[7] = '{0, 1'b1, 1'b0, 32'd1024,   32'h0,        1'b0, 18'd0, 32'hCAFEF00D};
      vecs[8] = '{1, 1'b0, 1'b1, 32'd525312, 32'hA5A51234, 1'b0, 18'd0, 32'h00000000};
      vecs[9] = '{1, 1'b1, 1'b0, 32'd1024,   32'h0,        1'b0, 18'd0, 32'hA5A51234};

      for (int i = 0; i < HwSize; i++) begin
         sram_a[i] = 16'(i) ^ 16'h5a5a;
         sram_b[i] = 16'(i) ^ 16'h5a5a;
      end
      sram_oe_a = 1'b0;
      sram_oe_b = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      cur = 1'b0;
      rst = 1'b0;
      ifa.address = '0; ifa.write_data = '0;
      ifb.address = '0; ifb.write_data = '0;
      set_inputs(0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("reset ready no req", {31'h0, ifa.ready}, 32'h1);
      ifa.rd_en = 1'b1;
      #1;
      check("reset ready with req", {31'h0, ifa.ready}, 32'h0);
      ifa.rd_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(10);

      for (int i = 0; i < 10; i++) begin
         do_access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].scr,
                   fa, rdv);
         check($sformatf("vec%0d first addr", i), {14'h0, fa}, {14'h0, vecs[i].exp_addr});
         check($sformatf("vec%0d read_data", i), rdv, vecs[i].exp_rd);
      end

      // Reset pulled during the high phase of a load.
      cur = 1'b0;
      @(posedge clk); #1;
      set_inputs(0, 1'b1, 1'b0, 32'd1028, 32'h0);
      sram_oe_a = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("pre-reset high addr", {14'h0, addr_a}, 32'd3);
      rst = 1'b0;
      #1;
      check("async reset ready", {31'h0, ifa.ready}, 32'h0);
      check("async reset addr", {14'h0, addr_a}, 32'h0);
      check("async reset we_n", {31'h0, we_a}, 32'h1);
      check("async reset rd a", ifa.read_data, 32'h0);
      check("async reset rd b", ifb.read_data, 32'h0);
      ifa.rd_en = 1'b0;
      sram_oe_a = 1'b0;
      #1;
      check("reset ready after drop", {31'h0, ifa.ready}, 32'h1);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      @(negedge clk);
      rst = 1'b1;
      idle(10);

      for (int i = 0; i < 80; i++) begin
         d   = int'($urandom_range(0, 1));
         op  = int'($urandom_range(0, 2));
         wi  = int'($urandom_range(0, 7));
         a   = Base + 32'(4 * wi);
         if ($urandom_range(0, 4) == 0) a = a + 32'd524288;
         wd  = $urandom;
         scr = ($urandom_range(0, 3) == 0);
         do_access(d, op != 1, op != 0, a, wd, scr, fa, rdv);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
